// File: rtl/dma.sv
// Byte-wide controller for the shared on-chip RAM: single-byte reads and writes with
// a level request / one-cycle done handshake and a fixed, parameterised access latency.
module dma #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_data_in,
   input  logic              ram_read_signal,
   input  logic              ram_write_signal,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ram_done_read,
   output logic              ram_done_write
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   logic [3:0]        count;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              op_write;
   logic              commit;
   logic              any_req;
   logic [DATA_W-1:0] rd_data;

   logic [DATA_W-1:0] mem [DEPTH];

   // Commit point of the in-flight access and request summary.
   always_comb begin
      commit  = 1'b0;
      any_req = ram_read_signal | ram_write_signal;
      if ((state == BUSY) && (count == 4'd0)) begin
         commit = 1'b1;
      end else begin
         commit = 1'b0;
      end
   end

   assign rd_data = mem[addr];

   // RAM array write port; a commit edge that coincides with reset is dropped.
   always_ff @(posedge clk) begin
      if (RST && commit && op_write) begin
         mem[addr] <= wdata;
      end
   end

   // Access sequencer with registered data and done outputs.
   always_ff @(posedge clk) begin
      if (!RST) begin
         state          <= IDLE;
         count          <= 4'd0;
         addr           <= '0;
         wdata          <= '0;
         op_write       <= 1'b0;
         ram_data_out   <= '0;
         ram_done_read  <= 1'b0;
         ram_done_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ram_done_read  <= 1'b0;
               ram_done_write <= 1'b0;
               // Write wins when both requests are raised together.
               if (ram_write_signal) begin
                  addr     <= ram_address;
                  wdata    <= ram_data_in;
                  op_write <= 1'b1;
                  count    <= LOAD;
                  state    <= BUSY;
               end else if (ram_read_signal) begin
                  addr     <= ram_address;
                  op_write <= 1'b0;
                  count    <= LOAD;
                  state    <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (commit) begin
                  if (op_write) begin
                     ram_done_write <= 1'b1;
                  end else begin
                     ram_data_out  <= rd_data;
                     ram_done_read <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: begin
               ram_done_read  <= 1'b0;
               ram_done_write <= 1'b0;
               if (any_req) begin
                  state <= RELEASE;
               end else begin
                  state <= IDLE;
               end
            end
            RELEASE: begin
               // A held request must drop before another access is accepted.
               if (!any_req) begin
                  state <= IDLE;
               end else begin
                  state <= RELEASE;
               end
            end
            default: begin
               state          <= IDLE;
               ram_done_read  <= 1'b0;
               ram_done_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma.sv
// Directed self-checking bench for dma: one instance at LATENCY=1, one at LATENCY=4.
module tb_dma;

   logic        clk = 1'b0;
   logic        rst1, rd1, wr1;
   logic [15:0] addr1;
   logic [7:0]  din1, dout1;
   logic        dr1, dw1;
   logic        rst4, rd4, wr4;
   logic [15:0] addr4;
   logic [7:0]  din4, dout4;
   logic        dr4, dw4;
   int          checks = 0;
   int          errors = 0;
   int          pulses;

   always #5 clk = ~clk;

   dma #(.ADDR_W(16), .DATA_W(8), .LATENCY(1)) dut (
      .clk(clk), .RST(rst1), .ram_address(addr1), .ram_data_in(din1),
      .ram_read_signal(rd1), .ram_write_signal(wr1),
      .ram_data_out(dout1), .ram_done_read(dr1), .ram_done_write(dw1));

   dma #(.ADDR_W(16), .DATA_W(8), .LATENCY(4)) dut4 (
      .clk(clk), .RST(rst4), .ram_address(addr4), .ram_data_in(din4),
      .ram_read_signal(rd4), .ram_write_signal(wr4),
      .ram_data_out(dout4), .ram_done_read(dr4), .ram_done_write(dw4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- LATENCY=1 instance ----------------
      rst1 = 1'b0; rd1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0010; din1 = 8'hA5;
      rst4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0; addr4 = 16'h0000; din4 = 8'h00;
      tick(); tick();
      check("rst_dout", 16'(dout1), 16'h0000);
      check("rst_done_r", 16'(dr1), 16'h0000);
      check("rst_done_w", 16'(dw1), 16'h0000);
      // Release reset with both requests high: the write is accepted.
      rst1 = 1'b1;
      tick();
      check("acc_done_w", 16'(dw1), 16'h0000);
      tick();
      check("wr_done_w", 16'(dw1), 16'h0001);
      check("wr_done_r", 16'(dr1), 16'h0000);
      rd1 = 1'b0; wr1 = 1'b0;
      tick();
      check("wr_done_w_off", 16'(dw1), 16'h0000);

      // Read back 0x0010.
      rd1 = 1'b1;
      tick();
      check("rd_acc_done_r", 16'(dr1), 16'h0000);
      tick();
      check("rd_done_r", 16'(dr1), 16'h0001);
      check("rd_dout_a5", 16'(dout1), 16'h00A5);
      rd1 = 1'b0;
      tick();
      check("rd_done_r_off", 16'(dr1), 16'h0000);
      check("rd_dout_hold", 16'(dout1), 16'h00A5);

      // Write 0x3C to 0xFFFF, then hold a read there for 10 cycles.
      addr1 = 16'hFFFF; din1 = 8'h3C; wr1 = 1'b1;
      tick(); tick();
      check("wr_ffff_done", 16'(dw1), 16'h0001);
      wr1 = 1'b0;
      tick();
      rd1 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dr1) begin
            pulses++;
            check("held_dout", 16'(dout1), 16'h003C);
         end
      end
      check("held_pulses", 16'(pulses), 16'h0001);
      rd1 = 1'b0;
      tick();
      rd1 = 1'b1;
      tick(); tick();
      check("reacc_done_r", 16'(dr1), 16'h0001);
      check("reacc_dout", 16'(dout1), 16'h003C);
      rd1 = 1'b0;
      tick();

      // Simultaneous read+write: only the write is performed.
      addr1 = 16'h0001; din1 = 8'h5A; rd1 = 1'b1; wr1 = 1'b1;
      tick(); tick();
      check("sim_done_w", 16'(dw1), 16'h0001);
      check("sim_done_r", 16'(dr1), 16'h0000);
      check("sim_dout_keep", 16'(dout1), 16'h003C);
      rd1 = 1'b0; wr1 = 1'b0;
      tick();
      check("sim_no_late_r", 16'(dr1), 16'h0000);
      rd1 = 1'b1;
      tick(); tick();
      check("sim_rd_done", 16'(dr1), 16'h0001);
      check("sim_rd_dout", 16'(dout1), 16'h005A);
      rd1 = 1'b0;
      tick();

      // Input stability: pre-load 0x0030, then disturb inputs during BUSY.
      addr1 = 16'h0030; din1 = 8'h44; wr1 = 1'b1;
      tick(); tick();
      wr1 = 1'b0;
      tick();
      addr1 = 16'h0020; din1 = 8'h11; wr1 = 1'b1;
      tick();
      addr1 = 16'h0030; din1 = 8'h99;
      tick();
      check("stab_wr_done", 16'(dw1), 16'h0001);
      wr1 = 1'b0;
      tick();
      addr1 = 16'h0020; rd1 = 1'b1;
      tick();
      check("stab_rd_acc", 16'(dr1), 16'h0000);
      tick();
      check("stab_rd20", 16'(dout1), 16'h0011);
      rd1 = 1'b0;
      tick();
      addr1 = 16'h0030; rd1 = 1'b1;
      tick();
      addr1 = 16'h0020;
      tick();
      check("stab_rd30", 16'(dout1), 16'h0044);
      rd1 = 1'b0;
      tick();

      // ---------------- LATENCY=4 instance ----------------
      rst4 = 1'b1;
      tick();
      addr4 = 16'h0002; din4 = 8'h66; wr4 = 1'b1;
      tick();
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         pulses += int'(dw4);
      end
      check("l4_early_done", 16'(pulses), 16'h0000);
      tick();
      check("l4_done_w", 16'(dw4), 16'h0001);
      wr4 = 1'b0;
      tick();
      check("l4_done_w_off", 16'(dw4), 16'h0000);

      // Abort: reset two cycles after acceptance.
      din4 = 8'h77; wr4 = 1'b1;
      tick();
      wr4 = 1'b0;
      tick(); tick();
      rst4 = 1'b0;
      tick();
      rst4 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         pulses += int'(dw4) + int'(dr4);
      end
      check("abort_no_done", 16'(pulses), 16'h0000);
      rd4 = 1'b1;
      tick();
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         pulses += int'(dr4);
      end
      check("l4_rd_early", 16'(pulses), 16'h0000);
      tick();
      check("l4_rd_done", 16'(dr4), 16'h0001);
      check("abort_keep_old", 16'(dout4), 16'h0066);
      rd4 = 1'b0;
      tick();

      // Reset landing exactly on the commit edge must not commit.
      addr4 = 16'h0003; din4 = 8'h22; wr4 = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      wr4 = 1'b0;
      tick();
      din4 = 8'h55; wr4 = 1'b1;
      tick();
      wr4 = 1'b0;
      tick(); tick(); tick();
      rst4 = 1'b0;
      tick();
      check("commit_rst_done", 16'(dw4), 16'h0000);
      rst4 = 1'b1;
      tick();
      rd4 = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      check("commit_rst_done_r", 16'(dr4), 16'h0001);
      check("commit_rst_keep", 16'(dout4), 16'h0022);
      rd4 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
